// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared constants and types for the DRAM port arbiter
package dram_arb_pkg;
  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  typedef struct packed {
    logic we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;
  typedef struct packed {
    logic valid;
    logic [3:0] src;
  } rd_tag_t;
endpackage

// File: rtl/dram_port_arbiter_rr_pick.sv
// rr_pick: wrapped priority search over elig starting at start; ports elig/start in, idx/found out
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] elig,
  input  logic [2:0]   start,
  output logic [2:0]   idx,
  output logic         found
);
  localparam int W = $clog2(N);
  int j;
  always_comb begin
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (elig[j[W-1:0]]) begin
        idx = 3'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin share of one DRAM port between cores and host (host first); core_*/host_* requesters, mem_* DRAM port, optional stat_* outputs when DRAM_ARB_STATS_EN is defined
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  no_Cores,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_gnt,
  output logic                        host_rvalid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [NUM_CORES*16-1:0]     stat_grants,
  output logic [NUM_CORES*8-1:0]      stat_wait_max
`endif
);
  logic [3:0] n_act;
  logic [2:0] rr_ptr, start, win, ptr_nxt;
  logic found, take_host, sel_we;
  logic [NUM_CORES-1:0] elig, gnt_nxt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rd_tag_t tag1, tag2;
  always_comb begin
    n_act = (no_Cores == 3'd0) ? 4'd1 : {1'b0, no_Cores};
    start = ({1'b0, rr_ptr} >= n_act) ? 3'd0 : rr_ptr;
    take_host = host_req & ~host_gnt;
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    // a core granted this cycle still shows req, so it must sit out one decision
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = core_req[i] & (4'(i) < n_act) & ~core_gnt[i];
      if (win == 3'(i)) begin
        sel_we = core_we[i];
        sel_addr = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
      core_rvalid[i] = tag2.valid && tag2.src == 4'(i);
    end
    gnt_nxt = (!take_host && found) ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << win) : '0;
    ptr_nxt = (4'(win) + 4'd1 >= n_act) ? 3'd0 : win + 3'd1;
    host_rvalid = tag2.valid && tag2.src == 4'(NUM_CORES);
    core_rdata = tag2.valid ? mem_rdata : '0;
  end
  rr_pick #(.N(NUM_CORES)) u_pick (.elig(elig), .start(start), .idx(win), .found(found));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      core_gnt <= '0;
      host_gnt <= 1'b0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      host_gnt <= take_host;
      core_gnt <= gnt_nxt;
      tag2 <= tag1;
      if (take_host) begin
        mem_addr <= host_addr;
        mem_we <= host_we;
        mem_wdata <= host_wdata;
        tag1 <= '{valid: ~host_we, src: 4'(NUM_CORES)};
      end else if (found) begin
        mem_addr <= sel_addr;
        mem_we <= sel_we;
        mem_wdata <= sel_wdata;
        rr_ptr <= ptr_nxt;
        tag1 <= '{valid: ~sel_we, src: {1'b0, win}};
      end else begin
        mem_we <= 1'b0;
        tag1 <= '0;
      end
    end
  end
`ifdef DRAM_ARB_STATS_EN
  logic [7:0] wait_cnt [NUM_CORES];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants <= '0;
      stat_wait_max <= '0;
      for (int i = 0; i < NUM_CORES; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (gnt_nxt[i]) begin
          if (stat_grants[i*16 +: 16] != 16'hffff) stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
          // the decision cycle itself counts as one waiting cycle
          if ((wait_cnt[i] == 8'hff ? 8'hff : wait_cnt[i] + 8'd1) > stat_wait_max[i*8 +: 8])
            stat_wait_max[i*8 +: 8] <= (wait_cnt[i] == 8'hff) ? 8'hff : wait_cnt[i] + 8'd1;
          wait_cnt[i] <= '0;
        end else if (core_req[i] && !core_gnt[i] && wait_cnt[i] != 8'hff) begin
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed self-checking bench with a synchronous DRAM model
module tb_dram_port_arbiter;
  localparam int NC = 4, AW = 12, DW = 32;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] no_Cores = 3'd4;
  logic [NC-1:0] core_req = '0, core_we = '0, core_gnt, core_rvalid;
  logic [NC*AW-1:0] core_addr = '0;
  logic [NC*DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata, host_wdata = '0, mem_wdata, mem_rdata = '0;
  logic host_req = 1'b0, host_we = 1'b0, host_gnt, host_rvalid, mem_we;
  logic [AW-1:0] host_addr = '0, mem_addr;
  logic [DW-1:0] dram [0:(1<<AW)-1];
  logic [NC-1:0] exp_g, prev_g;
  int checks = 0, errors = 0;
`ifdef DRAM_ARB_STATS_EN
  logic [NC*16-1:0] stat_grants;
  logic [NC*8-1:0] stat_wait_max;
`endif
  dram_port_arbiter dut (
    .clk(clk), .reset(reset), .no_Cores(no_Cores),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DRAM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_wait_max(stat_wait_max)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) dram[mem_addr] <= mem_wdata;
    mem_rdata <= dram[mem_addr];
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int a = 0; a < (1 << AW); a++) dram[a] = '0;
    dram[12'h010] = 32'hDEADBEEF;
    dram[12'h006] = 32'h0000_0066;
    tick(); tick(); tick();
    chk("rst_core_gnt", 64'(core_gnt), 0);
    chk("rst_host_gnt", 64'(host_gnt), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_rvalid", 64'(core_rvalid), 0);
    chk("rst_rdata", 64'(core_rdata), 0);
    reset = 1'b0;
    // single read by core 2
    core_addr[2*AW +: AW] = 12'h010;
    core_req = 4'b0100;
    tick();
    chk("single_gnt", 64'(core_gnt), 64'b0100);
    chk("single_addr", 64'(mem_addr), 64'h010);
    chk("single_we", 64'(mem_we), 0);
    core_req = '0;
    tick();
    chk("single_rvalid", 64'(core_rvalid), 64'b0100);
    chk("single_rdata", 64'(core_rdata), 64'hDEADBEEF);
    chk("single_gnt_drop", 64'(core_gnt), 0);
    // host write wins over cores 0 and 1 (rr_ptr is 3 here)
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h005; host_wdata = 32'h0000_00AA;
    core_addr[0 +: AW] = 12'h005;
    core_addr[AW +: AW] = 12'h006;
    core_req = 4'b0011;
    tick();
    chk("host_gnt", 64'(host_gnt), 1);
    chk("host_core_gnt", 64'(core_gnt), 0);
    chk("host_we", 64'(mem_we), 1);
    chk("host_addr", 64'(mem_addr), 64'h005);
    chk("host_wdata", 64'(mem_wdata), 64'hAA);
    host_req = 1'b0;
    tick();
    chk("host_then_c0", 64'(core_gnt), 64'b0001);
    chk("host_gnt_drop", 64'(host_gnt), 0);
    chk("host_no_rvalid", 64'(host_rvalid), 0);
    core_req = 4'b0010;
    tick();
    chk("host_then_c1", 64'(core_gnt), 64'b0010);
    chk("c0_rvalid", 64'(core_rvalid), 64'b0001);
    chk("c0_rdata", 64'(core_rdata), 64'hAA);
    core_req = '0;
    tick();
    chk("c1_rvalid", 64'(core_rvalid), 64'b0010);
    chk("c1_rdata", 64'(core_rdata), 64'h66);
    chk("idle_gnt", 64'(core_gnt), 0);
    // reset while core 3 read is in flight
    core_addr = {NC{12'h010}};
    core_req = 4'b1000;
    tick();
    chk("mid_gnt", 64'(core_gnt), 64'b1000);
    core_req = '0;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(core_gnt), 0);
    chk("mid_rst_addr", 64'(mem_addr), 0);
    tick();
    chk("mid_rst_rvalid", 64'(core_rvalid), 0);
    chk("mid_rst_rdata", 64'(core_rdata), 0);
    reset = 1'b0;
    // round robin: all four cores reading continuously
    core_req = 4'b1111;
    prev_g = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = 4'b0001 << (k % 4);
      chk($sformatf("rr_gnt%0d", k), 64'(core_gnt), 64'(exp_g));
      chk($sformatf("rr_rvalid%0d", k), 64'(core_rvalid), 64'(prev_g));
      if (k > 0) chk($sformatf("rr_rdata%0d", k), 64'(core_rdata), 64'hDEADBEEF);
      prev_g = exp_g;
    end
    // mask to two cores, then widen back to four
    no_Cores = 3'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mask2_gnt%0d", k), 64'(core_gnt), 64'(4'b0001 << (k % 2)));
    end
    no_Cores = 3'd4;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mask4_gnt%0d", k), 64'(core_gnt), 64'(4'b0001 << k));
    end
    // no_Cores = 0 behaves as 1: core 0 only, never on consecutive cycles
    no_Cores = 3'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("n0_gnt%0d", k), 64'(core_gnt), (k % 2 == 0) ? 64'b0001 : 64'b0);
      if (k % 2 == 1) chk($sformatf("n0_idle_we%0d", k), 64'(mem_we), 0);
    end
    core_req = '0;
    tick();
    tick();
    chk("end_idle_gnt", 64'(core_gnt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
